imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 191 +++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - two-entry buffered RISC-V immediate decode stage
//
// Purpose: accepts raw instruction words with their PC, decodes the immediate
// format, the extended immediate and the illegal flag at push time, and holds
// up to two decoded entries in order for a valid/ready downstream consumer.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous discard of every buffered entry
//   in_valid/in_ready     upstream handshake; in_ir, in_pc payload
//   out_valid/out_ready   downstream handshake for the head entry
//   out_ir, out_pc        head entry payload
//   out_imm, out_fmt      extended immediate and its format code
//   out_illegal           head entry opcode/encoding unsupported
module imm_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit RV64_EN = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  // Decode of the incoming word; only captured when the word is pushed.
  logic [XLEN-1:0] d_imm;
  logic [2:0]      d_fmt;
  logic            d_ill;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_shift;

  assign opc      = in_ir[6:0];
  assign f3       = in_ir[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    d_imm = '0;
    d_fmt = FMT_NONE;
    d_ill = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111: begin
        d_fmt = FMT_I;
        d_imm = XLEN'($signed(in_ir[31:20]));
      end
      7'b0010011: begin
        if (is_shift) begin
          d_fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            d_imm = XLEN'(in_ir[25:20]);
          end else begin
            d_imm = XLEN'(in_ir[24:20]);
            // a 6-bit shift amount does not exist on a 32-bit datapath
            d_ill = in_ir[25];
          end
        end else begin
          d_fmt = FMT_I;
          d_imm = XLEN'($signed(in_ir[31:20]));
        end
      end
      7'b0011011: begin
        if (RV64_EN) begin
          if (is_shift) begin
            d_fmt = FMT_SHAMT;
            d_imm = XLEN'(in_ir[24:20]);
          end else begin
            d_fmt = FMT_I;
            d_imm = XLEN'($signed(in_ir[31:20]));
          end
        end else begin
          d_ill = 1'b1;
        end
      end
      7'b0100011: begin
        d_fmt = FMT_S;
        d_imm = XLEN'($signed({in_ir[31:25], in_ir[11:7]}));
      end
      7'b1100011: begin
        d_fmt = FMT_B;
        d_imm = XLEN'($signed({in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        d_fmt = FMT_U;
        d_imm = XLEN'($signed({in_ir[31:12], 12'b0}));
      end
      7'b1101111: begin
        d_fmt = FMT_J;
        d_imm = XLEN'($signed({in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0}));
      end
      7'b1110011: begin
        if (f3[2]) begin
          d_fmt = FMT_ZIMM;
          d_imm = XLEN'(in_ir[19:15]);
        end else begin
          d_fmt = FMT_I;
          d_imm = XLEN'($signed(in_ir[31:20]));
        end
      end
      7'b0110011, 7'b0001111: begin
        d_fmt = FMT_NONE;
      end
      // every listed opcode ends in 2'b11, so compressed words land here too
      default: d_ill = 1'b1;
    endcase
    // an illegal entry never carries a format or immediate
    if (d_ill) begin
      d_fmt = FMT_NONE;
      d_imm = '0;
    end
  end

  // Two-slot circular buffer with a registered occupancy count.
  logic [31:0]     ir_q  [2];
  logic [XLEN-1:0] pc_q  [2];
  logic [XLEN-1:0] imm_q [2];
  logic [2:0]      fmt_q [2];
  logic            ill_q [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ir_q[i]  <= '0;
        pc_q[i]  <= '0;
        imm_q[i] <= '0;
        fmt_q[i] <= FMT_NONE;
        ill_q[i] <= 1'b0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        ir_q[wr_ptr]  <= in_ir;
        pc_q[wr_ptr]  <= in_pc;
        imm_q[wr_ptr] <= d_imm;
        fmt_q[wr_ptr] <= d_fmt;
        ill_q[wr_ptr] <= d_ill;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs read only registered state; an empty stage presents all zeros.
  assign out_ir      = out_valid ? ir_q[rd_ptr]  : '0;
  assign out_pc      = out_valid ? pc_q[rd_ptr]  : '0;
  assign out_imm     = out_valid ? imm_q[rd_ptr] : '0;
  assign out_fmt     = out_valid ? fmt_q[rd_ptr] : FMT_NONE;
  assign out_illegal = out_valid ? ill_q[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - self-checking bench for imm_decode_stage (XLEN 32 and 64)
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ir;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_ir32, out_pc32, out_imm32;
  logic [2:0]  out_fmt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_ir64;
  logic [63:0] out_pc64, out_imm64;
  logic [2:0]  out_fmt64;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_ir(in_ir), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_ir(out_ir32), .out_pc(out_pc32),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_ir(out_ir64), .out_pc(out_pc64),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: in-order list of accepted words; decode from field rules.
  typedef struct {
    logic [31:0] ir;
    logic [63:0] pc;
  } entry_t;
  entry_t q[$];

  function automatic longint sx(input longint v, input int bits);
    if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic void ref_decode(input logic [31:0] ir, input bit x64,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint u;
    longint v;
    int op;
    int f3;
    u   = longint'({32'b0, ir});
    op  = int'(u & 127);
    f3  = int'((u >> 12) & 7);
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    if (op == 'h03 || op == 'h67 || (op == 'h13 && f3 != 1 && f3 != 5) ||
        (op == 'h73 && f3 < 4) || (op == 'h1B && x64 && f3 != 1 && f3 != 5)) begin
      fmt = 3'd1; v = sx(u >> 20, 12);
    end else if (op == 'h13) begin
      fmt = 3'd6;
      if (x64) v = (u >> 20) & 63;
      else begin v = (u >> 20) & 31; ill = ((u >> 25) & 1) != 0; end
    end else if (op == 'h1B && x64) begin
      fmt = 3'd6; v = (u >> 20) & 31;
    end else if (op == 'h23) begin
      fmt = 3'd2; v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
    end else if (op == 'h63) begin
      fmt = 3'd3;
      v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
             (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
    end else if (op == 'h37 || op == 'h17) begin
      fmt = 3'd4; v = sx(u & 'hFFFFF000, 32);
    end else if (op == 'h6F) begin
      fmt = 3'd5;
      v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
             (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
    end else if (op == 'h73) begin
      fmt = 3'd7; v = (u >> 15) & 31;
    end else if (op == 'h33 || op == 'h0F) begin
      fmt = 3'd0;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin fmt = 3'd0; v = 0; end
    imm = x64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
  endfunction

  task automatic check_all();
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    chk("in_ready32", 64'(in_ready32), 64'(q.size() != 2));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() != 2));
    chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_ir32", 64'(out_ir32), 64'(q[0].ir));
      chk("out_ir64", 64'(out_ir64), 64'(q[0].ir));
      chk("out_pc32", 64'(out_pc32), q[0].pc & 64'hFFFF_FFFF);
      chk("out_pc64", out_pc64, q[0].pc);
      ref_decode(q[0].ir, 1'b0, imm, fmt, ill);
      chk("out_imm32", 64'(out_imm32), imm);
      chk("out_fmt32", 64'(out_fmt32), 64'(fmt));
      chk("out_ill32", 64'(out_illegal32), 64'(ill));
      ref_decode(q[0].ir, 1'b1, imm, fmt, ill);
      chk("out_imm64", out_imm64, imm);
      chk("out_fmt64", 64'(out_fmt64), 64'(fmt));
      chk("out_ill64", 64'(out_illegal64), 64'(ill));
    end else begin
      chk("idle_imm32", 64'(out_imm32), 64'd0);
      chk("idle_imm64", out_imm64, 64'd0);
      chk("idle_fmt", 64'({out_fmt32, out_fmt64}), 64'd0);
      chk("idle_ill", 64'({out_illegal32, out_illegal64}), 64'd0);
    end
  endtask

  // Drive one cycle from a negedge, advance the model, then check at the next negedge.
  task automatic step(input logic v, input logic [31:0] ir, input logic [63:0] pc,
                      input logic ordy, input logic fl);
    int n;
    entry_t e;
    in_valid  = v;
    in_ir     = ir;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    n = q.size();
    if (fl) begin
      q.delete();
    end else begin
      if (n > 0 && ordy) void'(q.pop_front());
      if (v && n != 2) begin
        e.ir = ir; e.pc = pc;
        q.push_back(e);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  logic [6:0] opcodes [14] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F, 7'h3B};

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'({in_ready32, in_ready64}), 64'h3);
    chk("rst_out_valid", 64'({out_valid32, out_valid64}), 64'h0);
    chk("rst_out_ir", 64'(out_ir32), 64'd0);
    chk("rst_out_imm", out_imm64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first accept happens on the first edge with rst_n high
    step(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
    chk("addi_imm", 64'(out_imm32), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(out_fmt32), 64'd1);
    chk("addi_ill", 64'(out_illegal32), 64'd0);
    step(1'b1, 32'hFE112E23, 64'h1004, 1'b1, 1'b0);
    chk("sw_imm", 64'(out_imm32), 64'hFFFF_FFFC);
    chk("sw_fmt", 64'(out_fmt32), 64'd2);
    step(1'b1, 32'h0080006F, 64'h1008, 1'b1, 1'b0);
    chk("jal_imm", 64'(out_imm32), 64'h8);
    chk("jal_fmt", 64'(out_fmt32), 64'd5);
    step(1'b1, 32'h4030D093, 64'h100C, 1'b1, 1'b0);
    chk("srai_imm", 64'(out_imm32), 64'h3);
    chk("srai_fmt", 64'(out_fmt32), 64'd6);
    step(1'b1, 32'h0000007F, 64'h1010, 1'b1, 1'b0);
    chk("bad_op", 64'({out_illegal32, out_fmt32}), 64'h8);
    chk("bad_op_imm", 64'(out_imm32), 64'd0);
    step(1'b1, 32'h02009093, 64'h1014, 1'b1, 1'b0);
    chk("slli32_ill", 64'(out_illegal32), 64'd1);
    chk("slli64_imm", out_imm64, 64'd32);
    step(1'b1, 32'h80000037, 64'h1018, 1'b1, 1'b0);
    chk("lui64_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // backpressure: A, B buffered, C held upstream until room appears
    step(1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 64'h2004, 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready32), 64'd0);
    step(1'b1, 32'h00300193, 64'h2008, 1'b0, 1'b0);
    chk("hold_head_A", 64'(out_ir32), 64'h00100093);
    step(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
    chk("head_B", 64'(out_ir32), 64'h00200113);
    step(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
    chk("head_C", 64'(out_ir32), 64'h00300193);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("drained", 64'(out_valid32), 64'd0);

    // flush at count 2 with a simultaneous push
    step(1'b1, 32'h00400213, 64'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 64'h3004, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 64'h3008, 1'b0, 1'b1);
    chk("flush_valid", 64'({out_valid32, out_valid64}), 64'd0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("flush_absent", 64'(out_valid32), 64'd0);

    // asynchronous reset with two entries held
    step(1'b1, 32'h00700393, 64'h4000, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 64'h4004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'({out_valid32, out_valid64}), 64'd0);
    chk("async_rst_ready", 64'({in_ready32, in_ready64}), 64'h3);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h00900493, 64'h5000, 1'b0, 1'b0);
    chk("post_rst_accept", 64'(out_ir32), 64'h00900493);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom();
      if ($urandom_range(0, 7) != 0) r[6:0] = opcodes[$urandom_range(0, 13)];
      step($urandom_range(0, 9) < 7, r, {$urandom(), $urandom()},
           $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
